smol_alu_arb: RTL and testbench

- Shares one smolCore ALU instance between two requesters: port 0 is execute, port 1 is load/store address generation.
- Each requester uses a valid/ready request handshake.
- The block selects one requester per cycle, drives the ALU operand and op_sel inputs from it, and captures the ALU result into a one-entry output register.
- The output register carries a response handshake and a requester ID.
- Sits between issue logic and the shared ALU; the ALU instance stays purely combinational.

---
 rtl/smol_alu_arb.sv | 149 ++++++++++++++
 tb/tb_smol_alu_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smol_alu_arb.sv
// Two-port arbiter in front of a shared combinational smolCore ALU, with a one-entry result register.
// Optional per-requester handshake counters are enabled by defining SMOL_ALU_ARB_PERF_CNT_EN.
module smol_alu_arb #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2_or_imm,
  output logic [OP_W-1:0]   alu_op_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data
`ifdef SMOL_ALU_ARB_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_cnt0,
  output logic [15:0]       perf_cnt1
`endif
);

  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rr_last;

  logic w_free;
  logic w_gnt_vld;
  logic w_gnt_id;
  logic w_hs;

  // Result slot can take a new result when empty or being drained this cycle.
  assign w_free = !r_rsp_valid || rsp_ready;
  assign w_hs   = w_gnt_vld && w_free;

  // Grant selection: lone requester wins, otherwise fixed or round-robin priority.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = (FIXED_PRIO != 0) ? 1'b0 : ~r_rr_last;
    end else if (req0_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (req1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end else begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 1'b0;
    end
  end

  assign req0_ready = w_free && w_gnt_vld && !w_gnt_id;
  assign req1_ready = w_free && w_gnt_vld && w_gnt_id;

  // ALU operand mux; the all-ones op with zero operands makes an idle ALU output zero.
  always_comb begin
    alu_rs1        = {DATA_W{1'b0}};
    alu_rs2_or_imm = {DATA_W{1'b0}};
    alu_op_sel     = {OP_W{1'b1}};
    case ({w_gnt_vld, w_gnt_id})
      2'b10: begin
        alu_rs1        = req0_a;
        alu_rs2_or_imm = req0_b;
        alu_op_sel     = req0_op;
      end
      2'b11: begin
        alu_rs1        = req1_a;
        alu_rs2_or_imm = req1_b;
        alu_op_sel     = req1_op;
      end
      default: begin
        alu_rs1        = {DATA_W{1'b0}};
        alu_rs2_or_imm = {DATA_W{1'b0}};
        alu_op_sel     = {OP_W{1'b1}};
      end
    endcase
  end

  // Result register and round-robin history; priority only rotates on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= {DATA_W{1'b0}};
      r_rr_last   <= 1'b1;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_id;
      r_rsp_data  <= alu_out;
      r_rr_last   <= w_gnt_id;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

`ifdef SMOL_ALU_ARB_PERF_CNT_EN
  logic [15:0] r_perf_cnt0;
  logic [15:0] r_perf_cnt1;

  // Saturating handshake counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt0 <= 16'd0;
      r_perf_cnt1 <= 16'd0;
    end else if (perf_clr) begin
      r_perf_cnt0 <= 16'd0;
      r_perf_cnt1 <= 16'd0;
    end else begin
      if (w_hs && !w_gnt_id && (r_perf_cnt0 != 16'hFFFF)) begin
        r_perf_cnt0 <= r_perf_cnt0 + 16'd1;
      end else begin
        r_perf_cnt0 <= r_perf_cnt0;
      end
      if (w_hs && w_gnt_id && (r_perf_cnt1 != 16'hFFFF)) begin
        r_perf_cnt1 <= r_perf_cnt1 + 16'd1;
      end else begin
        r_perf_cnt1 <= r_perf_cnt1;
      end
    end
  end

  assign perf_cnt0 = r_perf_cnt0;
  assign perf_cnt1 = r_perf_cnt1;
`endif

endmodule

// File: tb/tb_smol_alu_arb.sv
// Self-checking bench for smol_alu_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model; a second instance covers fixed priority.
module tb_smol_alu_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_rs1, alu_rs2_or_imm, alu_out;
  logic [4:0]  alu_op_sel;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  logic        f_v0, f_v1, f_rdy0, f_rdy1;
  logic [4:0]  f_op0, f_op1, f_alu_op;
  logic [31:0] f_a0, f_b0, f_a1, f_b1, f_alu_rs1, f_alu_rs2, f_alu_out;
  logic        f_rsp_valid, f_rsp_ready, f_rsp_id;
  logic [31:0] f_rsp_data;

`ifdef SMOL_ALU_ARB_PERF_CNT_EN
  logic        perf_clr, f_perf_clr;
  logic [15:0] perf_cnt0, perf_cnt1, f_perf_cnt0, f_perf_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the result slot should hold and who was served last.
  logic        m_rv;
  logic        m_rid;
  logic [31:0] m_rdata;
  logic        m_rr;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << b[4:0];
      5'd13:   return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out   = alu_f(alu_op_sel, alu_rs1, alu_rs2_or_imm);
  assign f_alu_out = alu_f(f_alu_op, f_alu_rs1, f_alu_rs2);

  smol_alu_arb #(.DATA_W(32), .OP_W(5), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_rs1(alu_rs1), .alu_rs2_or_imm(alu_rs2_or_imm), .alu_op_sel(alu_op_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef SMOL_ALU_ARB_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
  );

  smol_alu_arb #(.DATA_W(32), .OP_W(5), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_v0), .req0_ready(f_rdy0), .req0_op(f_op0), .req0_a(f_a0), .req0_b(f_b0),
    .req1_valid(f_v1), .req1_ready(f_rdy1), .req1_op(f_op1), .req1_a(f_a1), .req1_b(f_b1),
    .alu_rs1(f_alu_rs1), .alu_rs2_or_imm(f_alu_rs2), .alu_op_sel(f_alu_op), .alu_out(f_alu_out),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data)
`ifdef SMOL_ALU_ARB_PERF_CNT_EN
    , .perf_clr(f_perf_clr), .perf_cnt0(f_perf_cnt0), .perf_cnt1(f_perf_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rules: -1 = nobody requesting.
  function automatic int pick(input logic v0, input logic v1, input logic rr_last, input bit fixed);
    if (v0 && v1) return fixed ? 0 : (rr_last ? 0 : 1);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_rv = 1'b0; m_rid = 1'b0; m_rdata = 32'd0; m_rr = 1'b1;
  endtask

  // One clock cycle: entered just after a falling edge with inputs already driven.
  task automatic step(output bit hs0, output bit hs1);
    int   g;
    logic free;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("rsp_data", rsp_data, m_rdata);
    #1;
    g    = pick(req0_valid, req1_valid, m_rr, 1'b0);
    free = !m_rv || rsp_ready;
    hs0  = free && (g == 0);
    hs1  = free && (g == 1);
    chk("req0_ready", 32'(req0_ready), 32'(hs0));
    chk("req1_ready", 32'(req1_ready), 32'(hs1));
    chk("alu_rs1", alu_rs1, (g == 0) ? req0_a : (g == 1) ? req1_a : 32'd0);
    chk("alu_rs2", alu_rs2_or_imm, (g == 0) ? req0_b : (g == 1) ? req1_b : 32'd0);
    chk("alu_op", 32'(alu_op_sel), (g == 0) ? 32'(req0_op) : (g == 1) ? 32'(req1_op) : 32'd31);
    @(posedge clk);
    if (hs0) begin
      m_rv = 1'b1; m_rid = 1'b0; m_rr = 1'b0; m_rdata = alu_f(req0_op, req0_a, req0_b);
    end else if (hs1) begin
      m_rv = 1'b1; m_rid = 1'b1; m_rr = 1'b1; m_rdata = alu_f(req1_op, req1_a, req1_b);
    end else if (rsp_ready) begin
      m_rv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit h0, h1;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0;
    f_v0 = 1'b0; f_v1 = 1'b0; f_op0 = 5'd0; f_op1 = 5'd0;
    f_a0 = 32'd0; f_b0 = 32'd0; f_a1 = 32'd0; f_b1 = 32'd0; f_rsp_ready = 1'b1;
`ifdef SMOL_ALU_ARB_PERF_CNT_EN
    perf_clr = 1'b0; f_perf_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_op", 32'(alu_op_sel), 32'd31);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from execute port.
    req0_valid = 1'b1; req0_op = 5'd0; req0_a = 32'd5; req0_b = 32'd7;
    step(h0, h1);
    req0_valid = 1'b0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_data", rsp_data, 32'd12);
    step(h0, h1);

    // Round-robin from a fresh reset.
    do_reset();
    req0_valid = 1'b1; req0_op = 5'd1;  req0_a = 32'd10;    req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 5'd13; req1_a = 32'h100;   req1_b = 32'h20;
    for (int i = 0; i < 4; i++) begin
      step(h0, h1);
      chk("rr_id", 32'(rsp_id), 32'(i % 2));
      chk("rr_data", rsp_data, (i % 2 == 0) ? 32'd7 : 32'h120);
    end

    // Backpressure: slot full and not drained, nothing may be accepted.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(h0, h1);
      chk("bp_data", rsp_data, 32'h120);
    end
    rsp_ready = 1'b1;
    step(h0, h1);
    chk("bp_release_id", 32'(rsp_id), 32'd0);
    chk("bp_release_data", rsp_data, 32'd7);

    // Asynchronous reset between edges while a result is held.
    chk("mid_valid_before", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(h0, h1);
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(h0, h1);

    // Fixed-priority instance: requester 0 wins every cycle.
    f_v0 = 1'b1; f_op0 = 5'd0; f_a0 = 32'd20; f_b0 = 32'd22;
    f_v1 = 1'b1; f_op1 = 5'd4; f_a1 = 32'hF0F0; f_b1 = 32'h0FF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fix_rdy0", 32'(f_rdy0), 32'd1);
      chk("fix_rdy1", 32'(f_rdy1), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("fix_valid", 32'(f_rsp_valid), 32'd1);
      chk("fix_id", 32'(f_rsp_id), 32'd0);
      chk("fix_data", f_rsp_data, 32'd42);
    end
    f_v0 = 1'b0; f_v1 = 1'b0;

    // Randomized traffic; a pending request holds its payload until accepted.
    h0 = 1'b1; h1 = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (!req0_valid || h0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 5'($urandom_range(0, 31));
        req0_a = $urandom; req0_b = $urandom;
      end
      if (!req1_valid || h1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 5'($urandom_range(0, 31));
        req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(h0, h1);
    end

`ifdef SMOL_ALU_ARB_PERF_CNT_EN
    // Clear during a handshake, then saturate the load/store counter.
    req0_valid = 1'b0; req1_valid = 1'b1; req1_op = 5'd0; rsp_ready = 1'b1;
    perf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_clr_cnt0", 32'(perf_cnt0), 32'd0);
    chk("perf_clr_cnt1", 32'(perf_cnt1), 32'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("perf_cnt1_100", 32'(perf_cnt1), 32'd100);
    repeat (69900) @(posedge clk);
    @(negedge clk);
    chk("perf_sat_cnt1", 32'(perf_cnt1), 32'h0000FFFF);
    chk("perf_sat_cnt0", 32'(perf_cnt0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
